// File: rtl/lcd_text_pkg.sv
// Shared constants, state encoding and character filter for the HD44780 text frame writer.
package lcd_text_pkg;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_LINE2_ADDR    = 8'h40;
  localparam logic [7:0] LCD_CHAR_SPACE    = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE_CMD,
    S_CHAR,
    S_DONE
  } state_e;

  // Anything outside printable ASCII shows as a blank cell.
  function automatic logic [7:0] lcd_sanitize(input logic [7:0] c);
    return ((c < 8'h20) || (c > 8'h7E)) ? LCD_CHAR_SPACE : c;
  endfunction

endpackage

// File: rtl/lcd_text_buf.sv
// Frame buffer: DEPTH x 8 register array that resets to spaces, one write port, one combinational read port.
module lcd_text_buf
  import lcd_text_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_char
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_d[wr_addr] = wr_char;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= LCD_CHAR_SPACE;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_char = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : LCD_CHAR_SPACE;

endmodule

// File: rtl/lcd_text_frame_writer.sv
// Streams a ROWS x COLS text frame to the HD44780 controller FIFO as DDRAM-address commands plus characters.
// Optional build macro LCD_TEXT_SANITIZE_EN blanks non-printable characters on output.
module lcd_text_frame_writer
  import lcd_text_pkg::*;
#(
  parameter int          COLS       = 16,
  parameter int          ROWS       = 2,
  parameter logic [7:0]  LINE2_ADDR = LCD_LINE2_ADDR,
  localparam int         DEPTH      = ROWS * COLS,
  localparam int         ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int         COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              refresh_req,
  input  logic              lcd_init_done,
  input  logic              lcd_data_ready,
  output logic [7:0]        lcd_data,
  output logic              lcd_data_valid,
  output logic              lcd_is_cmd,
  output logic              frame_busy,
  output logic              frame_done
);

  state_e            state_q, state_d;
  logic              row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              dirty_q, dirty_d;
  logic [7:0]        lcd_data_q, lcd_data_d;
  logic              lcd_data_valid_q, lcd_data_valid_d;
  logic              lcd_is_cmd_q, lcd_is_cmd_d;
  logic              frame_busy_q, frame_busy_d;
  logic              frame_done_q, frame_done_d;

  logic              wr_ok;
  logic              xfer;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_char;
  logic [7:0]        char_out;

  assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);
  assign xfer  = lcd_data_valid_q && lcd_data_ready;
  assign start = (state_q == S_IDLE) && dirty_q && lcd_init_done;

  lcd_text_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .rd_addr (rd_addr),
    .rd_char (rd_char)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dirty_d = dirty_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dirty_d = 1'b0;
          row_d   = 1'b0;
          col_d   = '0;
          state_d = S_LINE_CMD;
        end
      end
      S_LINE_CMD: begin
        if (xfer) state_d = S_CHAR;
      end
      S_CHAR: begin
        if (xfer) begin
          if (int'(col_q) < COLS - 1) begin
            col_d = col_q + COL_W'(1);
          end else if (int'(row_q) < ROWS - 1) begin
            row_d   = 1'b1;
            col_d   = '0;
            state_d = S_LINE_CMD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // New content arriving while the frame is being cleared must still win.
    if (wr_ok || refresh_req) dirty_d = 1'b1;
  end

  // The byte loaded next is addressed by the upcoming position, read from the live buffer.
  assign rd_addr = ADDR_W'(row_d) * ADDR_W'(COLS) + ADDR_W'(col_d);

`ifdef LCD_TEXT_SANITIZE_EN
  assign char_out = lcd_sanitize(rd_char);
`else
  assign char_out = rd_char;
`endif

  always_comb begin
    lcd_data_d       = lcd_data_q;
    lcd_data_valid_d = lcd_data_valid_q;
    lcd_is_cmd_d     = lcd_is_cmd_q;
    if (start || xfer) begin
      case (state_d)
        S_LINE_CMD: begin
          lcd_data_d       = LCD_CMD_SET_DDRAM | (row_d ? LINE2_ADDR : 8'h00);
          lcd_data_valid_d = 1'b1;
          lcd_is_cmd_d     = 1'b1;
        end
        S_CHAR: begin
          lcd_data_d       = char_out;
          lcd_data_valid_d = 1'b1;
          lcd_is_cmd_d     = 1'b0;
        end
        default: lcd_data_valid_d = 1'b0;
      endcase
    end
    frame_done_d = (state_d == S_DONE);
    frame_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      row_q            <= 1'b0;
      col_q            <= '0;
      dirty_q          <= 1'b1;
      lcd_data_q       <= 8'h00;
      lcd_data_valid_q <= 1'b0;
      lcd_is_cmd_q     <= 1'b1;
      frame_busy_q     <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      row_q            <= row_d;
      col_q            <= col_d;
      dirty_q          <= dirty_d;
      lcd_data_q       <= lcd_data_d;
      lcd_data_valid_q <= lcd_data_valid_d;
      lcd_is_cmd_q     <= lcd_is_cmd_d;
      frame_busy_q     <= frame_busy_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign lcd_data       = lcd_data_q;
  assign lcd_data_valid = lcd_data_valid_q;
  assign lcd_is_cmd     = lcd_is_cmd_q;
  assign frame_busy     = frame_busy_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_lcd_text_frame_writer.sv
// Directed self-checking bench for lcd_text_frame_writer (2x16 main instance plus a 1x5 instance for range checks).
module tb_lcd_text_frame_writer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       refresh_req;
  logic       lcd_init_done;
  logic       lcd_data_ready;
  logic [7:0] lcd_data;
  logic       lcd_data_valid;
  logic       lcd_is_cmd;
  logic       frame_busy;
  logic       frame_done;

  logic       s_wr_en;
  logic [2:0] s_wr_addr;
  logic [7:0] s_wr_char;
  logic [7:0] s_lcd_data;
  logic       s_lcd_data_valid;
  logic       s_lcd_is_cmd;
  logic       s_frame_busy;
  logic       s_frame_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_buf [32];
  logic [7:0] exp_data  [34];
  logic       exp_cmd   [34];

  always #5 clk = ~clk;

  lcd_text_frame_writer #(.COLS(16), .ROWS(2), .LINE2_ADDR(8'h40)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_char        (wr_char),
    .refresh_req    (refresh_req),
    .lcd_init_done  (lcd_init_done),
    .lcd_data_ready (lcd_data_ready),
    .lcd_data       (lcd_data),
    .lcd_data_valid (lcd_data_valid),
    .lcd_is_cmd     (lcd_is_cmd),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done)
  );

  lcd_text_frame_writer #(.COLS(5), .ROWS(1), .LINE2_ADDR(8'h40)) u_small (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (s_wr_en),
    .wr_addr        (s_wr_addr),
    .wr_char        (s_wr_char),
    .refresh_req    (1'b0),
    .lcd_init_done  (lcd_init_done),
    .lcd_data_ready (1'b1),
    .lcd_data       (s_lcd_data),
    .lcd_data_valid (s_lcd_data_valid),
    .lcd_is_cmd     (s_lcd_is_cmd),
    .frame_busy     (s_frame_busy),
    .frame_done     (s_frame_done)
  );

  function automatic logic [7:0] shown(input logic [7:0] c);
`ifdef LCD_TEXT_SANITIZE_EN
    return ((c < 8'h20) || (c > 8'h7E)) ? 8'h20 : c;
`else
    return c;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [7:0] c);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_char = c;
    model_buf[a] = c;
    @(negedge clk);
  endtask

  task automatic pulse_refresh();
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  // Called on a negedge; samples that cycle first. Returns on the negedge after frame_done.
  task automatic collect_frame(input string tag, input bit toggle, input int inj_idx,
                               input logic [4:0] inj_addr, input logic [7:0] inj_char,
                               output int first_cyc);
    int n = 0;
    int cyc = 0;
    int done_cyc;
    bit ph = 1'b1;
    bit stalled = 1'b0;
    bit injected = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic held_c = 1'b0;
    first_cyc = -1;
    exp_data[0] = 8'h80; exp_cmd[0] = 1'b1;
    exp_data[17] = 8'hC0; exp_cmd[17] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      exp_data[1 + c]  = shown(model_buf[c]);      exp_cmd[1 + c]  = 1'b0;
      exp_data[18 + c] = shown(model_buf[16 + c]); exp_cmd[18 + c] = 1'b0;
    end
    while (n < 34 && cyc < 400) begin
      if (inj_idx >= 0) begin
        if (n == inj_idx && !injected) begin
          wr_en = 1'b1; wr_addr = inj_addr; wr_char = inj_char;
          model_buf[inj_addr] = inj_char;
          injected = 1'b1;
        end else begin
          wr_en = 1'b0;
        end
      end
      if (stalled) begin
        checkOutput($sformatf("%s_stall_valid_c%0d", tag, cyc), 32'(lcd_data_valid), 32'd1);
        checkOutput($sformatf("%s_stall_data_c%0d", tag, cyc), 32'(lcd_data), 32'(held_d));
        checkOutput($sformatf("%s_stall_cmd_c%0d", tag, cyc), 32'(lcd_is_cmd), 32'(held_c));
      end
      lcd_data_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (lcd_data_valid && first_cyc < 0) begin
        first_cyc = cyc;
        checkOutput({tag, "_busy"}, 32'(frame_busy), 32'd1);
      end
      if (lcd_data_valid && lcd_data_ready) begin
        checkOutput($sformatf("%s_data_b%0d", tag, n), 32'(lcd_data), 32'(exp_data[n]));
        checkOutput($sformatf("%s_cmd_b%0d", tag, n), 32'(lcd_is_cmd), 32'(exp_cmd[n]));
        n++;
        stalled = 1'b0;
      end else if (lcd_data_valid) begin
        stalled = 1'b1;
        held_d  = lcd_data;
        held_c  = lcd_is_cmd;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0;
    lcd_data_ready = 1'b1;
    done_cyc = cyc;
    checkOutput({tag, "_len"}, 32'(n), 32'd34);
    checkOutput({tag, "_done_hi"}, 32'(frame_done), 32'd1);
    checkOutput({tag, "_done_valid"}, 32'(lcd_data_valid), 32'd0);
    if (!toggle) checkOutput({tag, "_latency"}, 32'(done_cyc - first_cyc), 32'd34);
    @(negedge clk);
    checkOutput({tag, "_done_lo"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int first;
    int cnt;
    $display("[TB] lcd_text_frame_writer directed test start");
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
    refresh_req = 1'b0; lcd_init_done = 1'b0; lcd_data_ready = 1'b1;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_char = '0;
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(lcd_data_valid), 32'd0);
    checkOutput("rst_data", 32'(lcd_data), 32'h00);
    checkOutput("rst_cmd", 32'(lcd_is_cmd), 32'd1);
    checkOutput("rst_busy", 32'(frame_busy), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);

    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("gated_valid", 32'(lcd_data_valid), 32'd0);

    // Frame of spaces after init completes.
    lcd_init_done = 1'b1;
    collect_frame("f_spaces", 1'b0, -1, 5'd0, 8'h00, first);
    checkOutput("f_spaces_first", 32'(first), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("idle_valid", 32'(lcd_data_valid), 32'd0);
    checkOutput("idle_busy", 32'(frame_busy), 32'd0);

    // Two host writes, one on each line.
    applyStimulus(5'd0, 8'h41);
    applyStimulus(5'd17, 8'h42);
    wr_en = 1'b0;
    collect_frame("f_ab", 1'b0, -1, 5'd0, 8'h00, first);

    // Ready toggling every cycle.
    pulse_refresh();
    collect_frame("f_toggle", 1'b1, -1, 5'd0, 8'h00, first);

    // Write to a position already sent; a second frame follows at once.
    pulse_refresh();
    collect_frame("f_mid", 1'b0, 8, 5'd5, 8'h58, first);
    collect_frame("f_follow", 1'b0, -1, 5'd0, 8'h00, first);
    checkOutput("f_follow_first", 32'(first), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("after_follow_valid", 32'(lcd_data_valid), 32'd0);

    // Init gate holds off a dirty buffer.
    lcd_init_done = 1'b0;
    pulse_refresh();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (lcd_data_valid) cnt++;
      @(negedge clk);
    end
    checkOutput("gate_100_valid", 32'(cnt), 32'd0);
    lcd_init_done = 1'b1;
    collect_frame("f_gate", 1'b0, -1, 5'd0, 8'h00, first);

    // Out-of-range write on the 1x5 instance is ignored; an in-range one triggers 6 bytes.
    s_wr_en = 1'b1; s_wr_addr = 3'd6; s_wr_char = 8'h41;
    @(negedge clk);
    s_wr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_lcd_data_valid) cnt++;
      @(negedge clk);
    end
    checkOutput("small_oor_valid", 32'(cnt), 32'd0);
    s_wr_en = 1'b1; s_wr_addr = 3'd2; s_wr_char = 8'h41;
    @(negedge clk);
    s_wr_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_lcd_data_valid) cnt++;
      @(negedge clk);
    end
    checkOutput("small_inrange_bytes", 32'(cnt), 32'd6);

    // Non-printable characters.
    applyStimulus(5'd0, 8'h07);
    applyStimulus(5'd1, 8'h7F);
    wr_en = 1'b0;
    collect_frame("f_sanitize", 1'b0, -1, 5'd0, 8'h00, first);

    // Reset in the middle of a frame.
    pulse_refresh();
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(lcd_data_valid), 32'd0);
    checkOutput("midrst_data", 32'(lcd_data), 32'h00);
    checkOutput("midrst_cmd", 32'(lcd_is_cmd), 32'd1);
    checkOutput("midrst_busy", 32'(frame_busy), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    reset_n = 1'b1;
    collect_frame("f_postrst", 1'b0, -1, 5'd0, 8'h00, first);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
